// File: rtl/mem_dbus_stage.sv
// Memory-access stage: issues loads/stores (incl. LL/SC) over a req/ack data bus,
// stalls the pipeline until completion, and aligns/extends load data for write-back.
module mem_dbus_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic        LLbit_i,
  input  logic        wb_LLbit_we_i,
  input  logic        wb_LLbit_value_i,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        LLbit_we_o,
  output logic        LLbit_value_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o
);
  localparam logic [7:0] OP_LB = 8'hE0, OP_LBU = 8'hE4, OP_LH = 8'hE1, OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW = 8'hE3, OP_SB = 8'hE8, OP_SH = 8'hE9, OP_SW = 8'hEB;
  localparam logic [7:0] OP_LL = 8'hF0, OP_SC = 8'hF8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        dbus_req_q, dbus_req_d, dbus_we_q, dbus_we_d;
  logic [31:0] dbus_addr_q, dbus_addr_d, dbus_wdata_q, dbus_wdata_d;
  logic [3:0]  dbus_sel_q, dbus_sel_d;
  logic [31:0] hold_wdata_q, hold_wdata_d;
  logic [4:0]  hold_wd_q, hold_wd_d;
  logic        hold_wreg_q, hold_wreg_d, hold_llwe_q, hold_llwe_d, hold_llval_q, hold_llval_d;

  logic is_byte, is_half, is_word, is_load, is_store, is_ll, is_sc;
  logic misalign, llbit_fwd, sc_fail, need_bus;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata, load_data;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  assign is_ll    = (aluop_i == OP_LL);
  assign is_sc    = (aluop_i == OP_SC);
  assign is_byte  = (aluop_i == OP_LB) || (aluop_i == OP_LBU) || (aluop_i == OP_SB);
  assign is_half  = (aluop_i == OP_LH) || (aluop_i == OP_LHU) || (aluop_i == OP_SH);
  assign is_word  = (aluop_i == OP_LW) || (aluop_i == OP_SW) || is_ll || is_sc;
  assign is_load  = (aluop_i == OP_LB) || (aluop_i == OP_LBU) || (aluop_i == OP_LH) ||
                    (aluop_i == OP_LHU) || (aluop_i == OP_LW) || is_ll;
  assign is_store = (aluop_i == OP_SB) || (aluop_i == OP_SH) || (aluop_i == OP_SW) || is_sc;

  assign misalign  = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
  assign llbit_fwd = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
  assign sc_fail   = is_sc && !llbit_fwd && !misalign;
  assign need_bus  = (is_load || is_store) && !misalign && !sc_fail;

  // Big-endian lane selection and store-data replication.
  always_comb begin
    req_sel   = 4'b1111;
    req_wdata = reg2_i;
    if (is_byte) begin
      req_sel   = 4'b1000 >> mem_addr_i[1:0];
      req_wdata = {4{reg2_i[7:0]}};
    end else if (is_half) begin
      req_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      req_wdata = {2{reg2_i[15:0]}};
    end
  end

  always_comb begin
    unique case (mem_addr_i[1:0])
      2'b00:   lane_byte = dbus_rdata_i[31:24];
      2'b01:   lane_byte = dbus_rdata_i[23:16];
      2'b10:   lane_byte = dbus_rdata_i[15:8];
      default: lane_byte = dbus_rdata_i[7:0];
    endcase
    lane_half = mem_addr_i[1] ? dbus_rdata_i[15:0] : dbus_rdata_i[31:16];
    unique case (aluop_i)
      OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_data = {24'd0, lane_byte};
      OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_data = {16'd0, lane_half};
      default: load_data = dbus_rdata_i;
    endcase
  end

  // NOTE: every next-state signal takes its current value first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    dbus_req_d   = dbus_req_q;
    dbus_we_d    = dbus_we_q;
    dbus_addr_d  = dbus_addr_q;
    dbus_sel_d   = dbus_sel_q;
    dbus_wdata_d = dbus_wdata_q;
    hold_wdata_d = hold_wdata_q;
    hold_wd_d    = hold_wd_q;
    hold_wreg_d  = hold_wreg_q;
    hold_llwe_d  = hold_llwe_q;
    hold_llval_d = hold_llval_q;
    unique case (state_q)
      S_IDLE: if (need_bus) begin
        state_d      = S_REQ;
        dbus_req_d   = 1'b1;
        dbus_we_d    = is_store;
        dbus_addr_d  = {mem_addr_i[31:2], 2'b00};
        dbus_sel_d   = req_sel;
        dbus_wdata_d = req_wdata;
      end
      S_REQ: if (dbus_ack_i) begin
        state_d      = S_DONE;
        dbus_req_d   = 1'b0;
        hold_wdata_d = is_sc ? 32'd1 : (is_load ? load_data : wdata_i);
        hold_wd_d    = wd_i;
        hold_wreg_d  = wreg_i;
        hold_llwe_d  = is_ll || is_sc;
        hold_llval_d = is_ll;
      end
      S_DONE: if (!stall[4]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_sel_q   <= '0;
      dbus_wdata_q <= '0;
      hold_wdata_q <= '0;
      hold_wd_q    <= '0;
      hold_wreg_q  <= 1'b0;
      hold_llwe_q  <= 1'b0;
      hold_llval_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dbus_req_q   <= dbus_req_d;
      dbus_we_q    <= dbus_we_d;
      dbus_addr_q  <= dbus_addr_d;
      dbus_sel_q   <= dbus_sel_d;
      dbus_wdata_q <= dbus_wdata_d;
      hold_wdata_q <= hold_wdata_d;
      hold_wd_q    <= hold_wd_d;
      hold_wreg_q  <= hold_wreg_d;
      hold_llwe_q  <= hold_llwe_d;
      hold_llval_q <= hold_llval_d;
    end
  end

  // While an access is outstanding the write-back fields are a bubble.
  always_comb begin
    wd_o          = wd_i;
    wreg_o        = wreg_i;
    wdata_o       = wdata_i;
    hi_o          = hi_i;
    lo_o          = lo_i;
    whilo_o       = whilo_i;
    LLbit_we_o    = 1'b0;
    LLbit_value_o = 1'b0;
    stallreq_o    = 1'b0;
    misalign_o    = 1'b0;
    if (rst) begin
      wd_o    = '0;
      wreg_o  = 1'b0;
      wdata_o = '0;
      hi_o    = '0;
      lo_o    = '0;
      whilo_o = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (misalign) begin
            misalign_o = 1'b1;
            wreg_o     = 1'b0;
          end else if (sc_fail) begin
            wreg_o  = 1'b1;
            wdata_o = '0;
          end else if (need_bus) begin
            stallreq_o = 1'b1;
            wreg_o     = 1'b0;
            wdata_o    = '0;
          end
        end
        S_REQ: begin
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
          wdata_o    = '0;
        end
        default: begin
          wd_o          = hold_wd_q;
          wreg_o        = hold_wreg_q;
          wdata_o       = hold_wdata_q;
          LLbit_we_o    = hold_llwe_q;
          LLbit_value_o = hold_llval_q;
        end
      endcase
    end
  end

  assign dbus_req_o   = dbus_req_q;
  assign dbus_we_o    = dbus_we_q;
  assign dbus_addr_o  = dbus_addr_q;
  assign dbus_sel_o   = dbus_sel_q;
  assign dbus_wdata_o = dbus_wdata_q;
endmodule

// File: tb/tb_mem_dbus_stage.sv
// Scoreboard bench for mem_dbus_stage: a driver issues ops and queues expectations from
// a behavioural model; a write-back monitor and a bus responder compare independently.
module tb_mem_dbus_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = '0, hi_i = '0, lo_i = '0, mem_addr_i = '0, reg2_i = '0;
  logic        whilo_i = 1'b0;
  logic [7:0]  aluop_i = 8'h00;
  logic        LLbit_i = 1'b0, wb_LLbit_we_i = 1'b0, wb_LLbit_value_i = 1'b0;
  logic [31:0] dbus_rdata_i = '0;
  logic        dbus_ack_i;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, LLbit_we_o, LLbit_value_o, stallreq_o, misalign_o;
  logic [31:0] wdata_o, hi_o, lo_o, dbus_addr_o, dbus_wdata_o;
  logic        dbus_req_o, dbus_we_o;
  logic [3:0]  dbus_sel_o;

  logic extra_hold = 1'b0, mon_en = 1'b0, resp_en = 1'b1;
  logic resp_ack = 1'b0, manual_ack = 1'b0;
  int   n_checks = 0, n_pass = 0;

  assign stall      = {1'b0, {5{stallreq_o | extra_hold}}};
  assign dbus_ack_i = resp_en ? resp_ack : manual_ack;

  always #5 clk = ~clk;

  mem_dbus_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .LLbit_i(LLbit_i), .wb_LLbit_we_i(wb_LLbit_we_i), .wb_LLbit_value_i(wb_LLbit_value_i),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
    .LLbit_we_o(LLbit_we_o), .LLbit_value_o(LLbit_value_o),
    .stallreq_o(stallreq_o), .misalign_o(misalign_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o)
  );

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        llwe, llval, mis;
    logic [31:0] hi, lo;
    logic        whilo;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        chk_wdata;
    int          delay;
    logic [31:0] rdata;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: derives the write-back result and bus transaction from the op rules.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] rdata, input logic llb, input logic wbwe,
                        input logic wbval, input int delay);
    exp_t e;
    bus_t b;
    bit   is_load, is_store, mis, fwd, need;
    int   size, off, stalls, cyc;
    logic [7:0]  b8;
    logic [15:0] h16;
    logic [31:0] ld;
    logic        cap;
    is_load  = op inside {8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hF0};
    is_store = op inside {8'hE8, 8'hE9, 8'hEB, 8'hF8};
    size = (op inside {8'hE0, 8'hE4, 8'hE8}) ? 1 :
           (op inside {8'hE1, 8'hE5, 8'hE9}) ? 2 : 4;
    off  = int'(addr[1:0]);
    mis  = (is_load || is_store) && (off % size != 0);
    fwd  = wbwe ? wbval : llb;
    need = (is_load || is_store) && !mis && !(op == 8'hF8 && !fwd);

    b8  = 8'(rdata >> (8 * (3 - off)));
    h16 = 16'(rdata >> (16 * (1 - off / 2)));
    if (size == 1)      ld = (op == 8'hE0) ? 32'($signed(b8))  : 32'(b8);
    else if (size == 2) ld = (op == 8'hE1) ? 32'($signed(h16)) : 32'(h16);
    else                ld = rdata;

    e.wd = wd_i; e.wreg = wreg_i; e.wdata = wdata_i; e.chk_wdata = 1'b1;
    e.llwe = 1'b0; e.llval = 1'b0; e.mis = 1'b0;
    e.hi = hi_i; e.lo = lo_i; e.whilo = whilo_i;
    if (mis) begin
      e.wreg = 1'b0; e.mis = 1'b1;
    end else if (op == 8'hF8 && !fwd) begin
      e.wreg = 1'b1; e.wdata = 32'd0;
    end else if (need) begin
      if (is_load) begin
        e.wdata = ld; e.llwe = (op == 8'hF0); e.llval = (op == 8'hF0);
      end else if (op == 8'hF8) begin
        e.wdata = 32'd1; e.llwe = 1'b1; e.llval = 1'b0;
      end else e.chk_wdata = 1'b0;
    end

    b.we = is_store; b.addr = addr & ~32'h3;
    b.sel = (size == 4) ? 4'hF : ((size == 1) ? 4'b1000 >> off : 4'b1100 >> off);
    b.wdata = (size == 1) ? reg2[7:0] * 32'h01010101 :
              (size == 2) ? reg2[15:0] * 32'h00010001 : reg2;
    b.chk_wdata = is_store; b.delay = delay; b.rdata = rdata;

    aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
    LLbit_i = llb; wb_LLbit_we_i = wbwe; wb_LLbit_value_i = wbval;
    exp_q.push_back(e);
    if (need) bus_q.push_back(b);

    stalls = 0;
    cyc = 0;
    forever begin
      extra_hold = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (stallreq_o) stalls++;
      cap = !stall[4];
      @(posedge clk);
      #1;
      if (cap) break;
      if (++cyc > 100) begin
        fail_now("op_timeout");
        break;
      end
    end
    extra_hold = 1'b0;
    check("stall_cycles", stalls, need ? delay + 2 : 0);
  endtask

  task automatic set_fields(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    hi_i = $urandom; lo_i = $urandom; whilo_i = 1'($urandom);
  endtask

  // Write-back monitor: one expectation per cycle in which mem_wb captures.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && !rst && !stall[4]) begin
      if (exp_q.size() == 0) fail_now("capture_without_op");
      else begin
        e = exp_q.pop_front();
        check("wd_o", wd_o, e.wd);
        check("wreg_o", wreg_o, e.wreg);
        if (e.chk_wdata) check("wdata_o", wdata_o, e.wdata);
        check("LLbit_we_o", LLbit_we_o, e.llwe);
        check("LLbit_value_o", LLbit_value_o, e.llval);
        check("misalign_o", misalign_o, e.mis);
        check("hi_o", hi_o, e.hi);
        check("lo_o", lo_o, e.lo);
        check("whilo_o", whilo_o, e.whilo);
      end
    end
  end

  // Bus responder: checks request fields, acks after the chosen delay, and throws in
  // spurious acks while no request is pending.
  always @(negedge clk) begin : responder
    bus_t b;
    int   cnt;
    logic in_req;
    if (resp_en) begin
      if (dbus_req_o) begin
        if (!in_req) begin
          in_req = 1'b1;
          if (bus_q.size() == 0) begin
            fail_now("unexpected_request");
            cnt = 0;
            b.rdata = 32'd0;
          end else begin
            b = bus_q.pop_front();
            check("dbus_we_o", dbus_we_o, b.we);
            check("dbus_addr_o", dbus_addr_o, b.addr);
            check("dbus_sel_o", dbus_sel_o, b.sel);
            if (b.chk_wdata) check("dbus_wdata_o", dbus_wdata_o, b.wdata);
            cnt = b.delay;
          end
        end
        if (cnt == 0) begin
          resp_ack = 1'b1;
          dbus_rdata_i = b.rdata;
        end else begin
          resp_ack = 1'b0;
          dbus_rdata_i = $urandom;
          cnt--;
        end
      end else begin
        in_req = 1'b0;
        resp_ack = ($urandom_range(0, 3) == 0);
        dbus_rdata_i = $urandom;
      end
    end
  end

  logic [7:0] mem_ops [10] = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB, 8'hF0, 8'hF8};

  initial begin
    logic [7:0] op;
    // Reset state: outputs zero while rst is high, bus fields cleared.
    set_fields(5'd7, 1'b1, 32'hDEADBEEF);
    hi_i = 32'h12345678; whilo_i = 1'b1; aluop_i = 8'hE3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wd_o", wd_o, 5'd0);
    check("rst_wdata_o", wdata_o, 32'd0);
    check("rst_hi_o", hi_o, 32'd0);
    check("rst_whilo_o", whilo_o, 1'b0);
    check("rst_stallreq_o", stallreq_o, 1'b0);
    check("rst_dbus_req_o", dbus_req_o, 1'b0);
    check("rst_dbus_sel_o", dbus_sel_o, 4'd0);
    aluop_i = 8'h21;
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed cases.
    set_fields(5'd3, 1'b1, 32'h0);
    run_op(8'hE3, 32'h100, 32'h0, 32'h11223344, 1'b0, 1'b0, 1'b0, 2);
    set_fields(5'd4, 1'b1, 32'h0);
    run_op(8'hE0, 32'h103, 32'h0, 32'h000000F0, 1'b0, 1'b0, 1'b0, 0);
    run_op(8'hE4, 32'h103, 32'h0, 32'h000000F0, 1'b0, 1'b0, 1'b0, 1);
    set_fields(5'd0, 1'b0, 32'h202);
    run_op(8'hE9, 32'h202, 32'h0000ABCD, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    set_fields(5'd9, 1'b1, 32'h400);
    run_op(8'hF0, 32'h400, 32'h0, 32'h55AA55AA, 1'b0, 1'b0, 1'b0, 0);
    run_op(8'hF8, 32'h400, 32'h12345678, 32'h0, 1'b0, 1'b1, 1'b1, 1);
    run_op(8'hF8, 32'h400, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    set_fields(5'd5, 1'b1, 32'h101);
    run_op(8'hE3, 32'h101, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    set_fields(5'd6, 1'b1, 32'hCAFE0001);
    run_op(8'h21, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0);

    // Randomised mix of memory, misaligned and pass-through ops.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        op = 8'($urandom);
        if (op inside {8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB, 8'hF0, 8'hF8})
          op = 8'h21;
      end else op = mem_ops[$urandom_range(0, 9)];
      set_fields(5'($urandom), 1'($urandom), $urandom);
      run_op(op, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3));
    end
    mon_en = 1'b0;
    check("exp_queue_drained", exp_q.size(), 0);
    check("bus_queue_drained", bus_q.size(), 0);

    // Reset during REQ, followed by a late ack.
    resp_en = 1'b0;
    manual_ack = 1'b0;
    set_fields(5'd2, 1'b1, 32'h0);
    aluop_i = 8'hE3; mem_addr_i = 32'h300;
    @(posedge clk);
    #1;
    check("rreq_dbus_req_up", dbus_req_o, 1'b1);
    rst = 1'b1;
    #1;
    check("rreq_stallreq_in_rst", stallreq_o, 1'b0);
    check("rreq_wreg_in_rst", wreg_o, 1'b0);
    check("rreq_lo_in_rst", lo_o, 32'd0);
    @(posedge clk);
    #1;
    check("rreq_dbus_req_dropped", dbus_req_o, 1'b0);
    check("rreq_dbus_addr_cleared", dbus_addr_o, 32'd0);
    rst = 1'b0;
    aluop_i = 8'h21; wdata_i = 32'hCAFEF00D; wreg_i = 1'b1;
    manual_ack = 1'b1;
    @(posedge clk);
    #1;
    manual_ack = 1'b0;
    check("late_ack_dbus_req", dbus_req_o, 1'b0);
    check("late_ack_stallreq", stallreq_o, 1'b0);
    check("late_ack_wdata_o", wdata_o, 32'hCAFEF00D);
    check("late_ack_llwe", LLbit_we_o, 1'b0);
    @(posedge clk);
    #1;
    check("late_ack_still_idle", dbus_req_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
